// File: rtl/pll_reconfig_seq.sv
// Reconfiguration sequencer for a Gowin rPLL in dynamic-divider mode.
// Holds the PLL in reset while the divider codes of the selected profile are
// applied, waits for LOCK, qualifies it for LOCK_STABLE cycles and then
// releases the downstream system reset. Any profile change, relock request
// or loss of lock re-runs the sequence; repeated lock timeouts end in FAIL.
module pll_reconfig_seq #(
    parameter logic [5:0] P0_IDSEL     = 6'd0,
    parameter logic [5:0] P0_FBDSEL    = 6'd0,
    parameter logic [5:0] P0_ODSEL     = 6'd32,
    parameter logic [5:0] P1_IDSEL     = 6'd4,
    parameter logic [5:0] P1_FBDSEL    = 6'd6,
    parameter logic [5:0] P1_ODSEL     = 6'd16,
    parameter int         RESET_CYCLES = 16,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       profile_sel,
    input  logic       relock_req,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       profile_active,
    output logic       sys_reset,
    output logic       busy,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_PLLRST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    // Terminal counter values: each phase ends on the edge that sees these.
    localparam logic [19:0] RST_LAST  = 20'(RESET_CYCLES - 1);
    localparam logic [19:0] STB_LAST  = 20'(LOCK_STABLE - 1);
    localparam logic [19:0] TMO_LAST  = 20'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state, state_next;
    logic [19:0] cnt, cnt_next;
    logic [3:0]  retry_next;
    logic        lock_meta, lock_s;
    logic        trigger;

    // Two-flop synchronizer for the asynchronous LOCK pin.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, which is what makes this a 2-stage chain.
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter and retry logic; restart trigger overrides all states.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt + 20'd1;
        retry_next = retry_count;
        trigger    = (profile_sel != profile_active) || relock_req;

        if (trigger) begin
            state_next = ST_PLLRST;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            unique case (state)
                ST_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Timeout outranks a lock seen on the same edge.
                    if (cnt == TMO_LAST) begin
                        cnt_next = '0;
                        if (retry_count < RETRY_MAX) begin
                            retry_next = 4'(retry_count + 4'd1);
                            state_next = ST_PLLRST;
                        end else begin
                            state_next = ST_FAIL;
                        end
                    end else if (lock_s) begin
                        state_next = ST_STABLE;
                        cnt_next   = 20'd1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                ST_RUN: begin
                    cnt_next = '0;
                    if (!lock_s) state_next = ST_PLLRST;
                end
                ST_FAIL: begin
                    cnt_next = '0;
                end
                default: begin
                    state_next = ST_PLLRST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; outputs decode the next state so
    // they change on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_PLLRST;
            cnt            <= '0;
            retry_count    <= '0;
            profile_active <= 1'b0;
            pll_idsel      <= P0_IDSEL;
            pll_fbdsel     <= P0_FBDSEL;
            pll_odsel      <= P0_ODSEL;
            pll_reset      <= 1'b1;
            sys_reset      <= 1'b1;
            busy           <= 1'b1;
            fail           <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            retry_count <= retry_next;
            // Dividers move only on trigger edges, which always (re)enter
            // PLLRST, so the PLL never sees a divider change out of reset.
            if (trigger) begin
                profile_active <= profile_sel;
                pll_idsel      <= profile_sel ? P1_IDSEL  : P0_IDSEL;
                pll_fbdsel     <= profile_sel ? P1_FBDSEL : P0_FBDSEL;
                pll_odsel      <= profile_sel ? P1_ODSEL  : P0_ODSEL;
            end
            pll_reset <= (state_next == ST_PLLRST) || (state_next == ST_FAIL);
            sys_reset <= (state_next != ST_RUN);
            busy      <= (state_next != ST_RUN) && (state_next != ST_FAIL);
            fail      <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: a table of input/expected-output steps
// walked in order, followed by hand-written reset and latency sequences.
module tb_pll_reconfig_seq;

    logic       clk = 1'b0;
    logic       reset, profile_sel, relock_req, pll_lock;
    logic       pll_reset, profile_active, sys_reset, busy, fail;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [3:0] retry_count;

    always #5 clk = ~clk;

    pll_reconfig_seq #(
        .RESET_CYCLES(16),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(100),
        .MAX_RETRY   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .profile_sel   (profile_sel),
        .relock_req    (relock_req),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .pll_idsel     (pll_idsel),
        .pll_fbdsel    (pll_fbdsel),
        .pll_odsel     (pll_odsel),
        .profile_active(profile_active),
        .sys_reset     (sys_reset),
        .busy          (busy),
        .fail          (fail),
        .retry_count   (retry_count)
    );

    // Output flag groups {pll_reset, sys_reset, busy, fail} per state.
    localparam logic [3:0] S_RST = 4'b1110;
    localparam logic [3:0] S_WT  = 4'b0110;
    localparam logic [3:0] S_RUN = 4'b0000;
    localparam logic [3:0] S_FL  = 4'b1101;

    typedef struct {
        logic       rst;
        logic       sel;
        logic       relock;
        logic       lock;
        int         cycles;
        logic [3:0] st;
        logic       prof;
        logic [3:0] retry;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic rst, input logic sel, input logic relock,
                               input logic lock, input int cycles, input logic [3:0] st,
                               input logic prof, input logic [3:0] retry);
        vec_t r;
        r.rst = rst; r.sel = sel; r.relock = relock; r.lock = lock;
        r.cycles = cycles; r.st = st; r.prof = prof; r.retry = retry;
        return r;
    endfunction

    // Expected output word: flags, profile, divider codes of that profile, retries.
    function automatic logic [31:0] exp_word(input logic [3:0] st, input logic prof,
                                             input logic [3:0] retry);
        logic [17:0] div;
        div = prof ? {6'd4, 6'd6, 6'd16} : {6'd0, 6'd0, 6'd32};
        return {5'd0, st, prof, div, retry};
    endfunction

    function automatic logic [31:0] act_word();
        return {5'd0, pll_reset, sys_reset, busy, fail, profile_active,
                pll_idsel, pll_fbdsel, pll_odsel, retry_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int waited;
        reset = 1'b1; profile_sel = 1'b0; relock_req = 1'b0; pll_lock = 1'b0;

        //                rst sel rl lck cyc  state prof retry
        // Boot on profile 0, lock arrives 10 cycles after pll_reset falls.
        tbl.push_back(v(1, 0, 0, 0,  3, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 15, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, S_WT,  0, 0));
        tbl.push_back(v(0, 0, 0, 0,  9, S_WT,  0, 0));
        tbl.push_back(v(0, 0, 0, 1,  9, S_WT,  0, 0));
        tbl.push_back(v(0, 0, 0, 1,  1, S_RUN, 0, 0));
        // Switch to profile 1 from RUN and relock.
        tbl.push_back(v(0, 1, 0, 0,  1, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 15, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  9, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  1, S_RUN, 1, 0));
        // Relock request, then a one-cycle lock glitch while qualifying.
        tbl.push_back(v(0, 1, 1, 0,  1, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 15, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  5, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  9, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  1, S_RUN, 1, 0));
        // Lock loss in RUN coinciding with relock_req: one 16-cycle pulse.
        tbl.push_back(v(0, 1, 0, 0,  2, S_RUN, 1, 0));
        tbl.push_back(v(0, 1, 1, 0,  1, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 15, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_WT,  1, 0));
        // Plain lock loss in RUN.
        tbl.push_back(v(0, 1, 0, 1,  9, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 1,  1, S_RUN, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  2, S_RUN, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_RST, 1, 0));
        // No lock at all: two retries, then FAIL after the third wait.
        tbl.push_back(v(0, 1, 0, 0, 15, S_RST, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 0, 99, S_WT,  1, 0));
        tbl.push_back(v(0, 1, 0, 0,  1, S_RST, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 16, S_WT,  1, 1));
        tbl.push_back(v(0, 1, 0, 0, 99, S_WT,  1, 1));
        tbl.push_back(v(0, 1, 0, 0,  1, S_RST, 1, 2));
        tbl.push_back(v(0, 1, 0, 0, 16, S_WT,  1, 2));
        tbl.push_back(v(0, 1, 0, 0, 99, S_WT,  1, 2));
        tbl.push_back(v(0, 1, 0, 0,  1, S_FL,  1, 2));
        tbl.push_back(v(0, 1, 0, 0,  5, S_FL,  1, 2));
        tbl.push_back(v(0, 1, 1, 0,  1, S_RST, 1, 0));
        // Back to profile 0, and a trigger inside PLLRST restarts the pulse.
        tbl.push_back(v(0, 0, 0, 0,  1, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 10, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 1, 0,  1, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 15, S_RST, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, S_WT,  0, 0));

        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            profile_sel = tbl[i].sel;
            relock_req  = tbl[i].relock;
            pll_lock    = tbl[i].lock;
            tick(tbl[i].cycles);
            check($sformatf("vec%0d", i), act_word(),
                  exp_word(tbl[i].st, tbl[i].prof, tbl[i].retry));
        end

        // Reset in the middle of STABLE with profile_sel already at 1.
        relock_req = 1'b0;
        pll_lock   = 1'b1;
        tick(4);
        check("stable_before_reset", act_word(), exp_word(S_WT, 1'b0, 4'd0));
        reset       = 1'b1;
        profile_sel = 1'b1;
        tick(1);
        check("reset_mid_stable", act_word(), exp_word(S_RST, 1'b0, 4'd0));
        reset = 1'b0;
        tick(1);
        check("profile1_after_reset", act_word(), exp_word(S_RST, 1'b1, 4'd0));
        tick(15);
        check("pulse_end_p1", act_word(), exp_word(S_RST, 1'b1, 4'd0));
        tick(1);
        check("wait_lock_p1", act_word(), exp_word(S_WT, 1'b1, 4'd0));

        // Lock already synced on WAIT_LOCK entry: RUN follows 8 edges later.
        waited = 0;
        while (sys_reset && waited < 50) begin
            tick(1);
            waited++;
        end
        check("run_latency", 32'(waited), 32'd8);
        check("run_state", act_word(), exp_word(S_RUN, 1'b1, 4'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
